// File: rtl/div_share_arbiter_pkg.sv
// Shared types for the divider share arbiter: the operand record, FSM states
// and the width helper for requester indices.
package div_share_arbiter_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CLZ_WIDTH  = $clog2(DIV_DATA_WIDTH);

  typedef struct packed {
    logic [DIV_DATA_WIDTH-1:0] dividend;
    logic [DIV_CLZ_WIDTH-1:0]  dividend_clz;
    logic [DIV_DATA_WIDTH-1:0] divisor;
    logic [DIV_CLZ_WIDTH-1:0]  divisor_clz;
    logic                      divisor_is_zero;
  } div_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_arb_state_t;

  function automatic int owner_width(input int num_requesters);
    return (num_requesters > 1) ? $clog2(num_requesters) : 1;
  endfunction

endpackage

// File: rtl/div_share_arbiter_rr_select.sv
// Combinational round-robin picker: first set pend bit at or after ptr,
// wrapping modulo N.
module div_rr_select
  import div_share_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = owner_width(N)
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_valid
);

  int idx;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    any_valid = |pend;
    // Walk from farthest to nearest so the candidate closest to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (pend[idx[IW-1:0]]) grant_idx = idx[IW-1:0];
    end
    grant[grant_idx] = any_valid;
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one unsigned divider between NUM_REQUESTERS (2..4) ports with
// round-robin issue. Define DIV_SHARE_ARBITER_BYPASS_EN to issue idle starts combinationally.
module div_share_arbiter
  import div_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
  parameter int NUM_REQUESTERS = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQUESTERS-1:0]           req_start,
  input  div_req_t [NUM_REQUESTERS-1:0]       req_op,
  output logic [NUM_REQUESTERS-1:0]           req_done,
  output logic [DATA_WIDTH-1:0]               req_quotient,
  output logic [DATA_WIDTH-1:0]               req_remainder,
  output logic [NUM_REQUESTERS-1:0]           req_busy,
  output logic                                div_start,
  output div_req_t                            div_op,
  input  logic                                div_done,
  input  logic [DATA_WIDTH-1:0]               div_quotient,
  input  logic [DATA_WIDTH-1:0]               div_remainder
);

  localparam int IW = owner_width(NUM_REQUESTERS);

  div_arb_state_t              state_q, state_d;
  logic [IW-1:0]               owner_q, rr_ptr_q;
  logic [NUM_REQUESTERS-1:0]   pend_q;
  div_req_t                    hold_q [NUM_REQUESTERS];
  div_req_t                    op_q;

  logic [NUM_REQUESTERS-1:0]   grant, accept, capture, clear_mask, owner_oh, bypass_mask;
  logic [IW-1:0]               grant_idx, issue_idx, next_ptr, bypass_idx;
  logic                        any_valid, issue, bypass_hit;
  div_req_t                    issue_op;

  div_rr_select #(.N(NUM_REQUESTERS)) u_rr (
    .pend      (pend_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign owner_oh = NUM_REQUESTERS'(1) << owner_q;
  assign req_busy = pend_q | ((state_q == BUSY) ? owner_oh : '0);

`ifdef DIV_SHARE_ARBITER_BYPASS_EN
  // Idle with nothing queued: hand the lowest-index start straight to the divider.
  always_comb begin
    bypass_hit = (state_q == IDLE) && (pend_q == '0) && (req_start != '0);
    bypass_idx = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (req_start[i]) bypass_idx = IW'(i);
    end
  end
`else
  assign bypass_hit = 1'b0;
  assign bypass_idx = '0;
`endif

  assign bypass_mask = bypass_hit ? (NUM_REQUESTERS'(1) << bypass_idx) : '0;
  // Starts from a busy requester are dropped so an in-flight buffer never changes.
  assign accept      = req_start & ~req_busy;
  assign capture     = accept & ~bypass_mask;
  assign clear_mask  = (issue && !bypass_hit) ? grant : '0;
  assign next_ptr    = (issue_idx == IW'(NUM_REQUESTERS - 1)) ? '0 : issue_idx + 1'b1;

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_idx = grant_idx;
    issue_op  = hold_q[grant_idx];
    if (bypass_hit) begin
      issue_idx = bypass_idx;
      issue_op  = req_op[bypass_idx];
    end
    unique case (state_q)
      IDLE: begin
        if (any_valid || bypass_hit) begin
          issue   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (div_done) state_d = IDLE;
      end
    endcase
    div_start = issue;
    div_op    = issue ? issue_op : op_q;
  end

  // NOTE: every register below uses non-blocking assignment so all of them
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      pend_q        <= '0;
      op_q          <= '0;
      req_done      <= '0;
      req_quotient  <= '0;
      req_remainder <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= (pend_q & ~clear_mask) | capture;
      req_done <= '0;
      if (issue) begin
        owner_q  <= issue_idx;
        rr_ptr_q <= next_ptr;
        op_q     <= issue_op;
      end
      if (state_q == BUSY && div_done) begin
        req_done      <= owner_oh;
        req_quotient  <= div_quotient;
        req_remainder <= div_remainder;
      end
    end
  end

  // NOTE: operand buffers carry no reset; pend_q alone marks them valid, so
  // resetting the wide data would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (capture[i]) hold_q[i] <= req_op[i];
    end
  end

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_proto
    a_no_busy_start: assert property (@(posedge clk) disable iff (!rst_n)
      !(req_start[g] && req_busy[g]))
      else $warning("div_share_arbiter: start on busy requester %0d dropped", g);
  end

  a_no_idle_done: assert property (@(posedge clk) disable iff (!rst_n)
    !(div_done && state_q == IDLE))
    else $warning("div_share_arbiter: div_done while idle ignored");

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: behavioural divider, issue-order
// and per-requester result scoreboards, vector table plus corner sequences.
module tb_div_share_arbiter;
  import div_share_arbiter_pkg::*;

  localparam int NREQ    = 2;
  localparam int DW      = DIV_DATA_WIDTH;
  localparam int DIV_LAT = 4;   // divider asserts div_done DIV_LAT cycles after div_start
`ifdef DIV_SHARE_ARBITER_BYPASS_EN
  localparam int ISSUE_LAT = 0;
`else
  localparam int ISSUE_LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } res_t;

  typedef struct {
    int            id;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          dz;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } vec_t;

  logic                    clk, rst_n;
  logic [NREQ-1:0]         req_start;
  div_req_t [NREQ-1:0]     req_op;
  logic [NREQ-1:0]         req_done, req_busy;
  logic [DW-1:0]           req_quotient, req_remainder;
  logic                    div_start, div_done;
  div_req_t                div_op;
  logic [DW-1:0]           div_quotient, div_remainder;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  res_t     exp_res [NREQ][$];
  div_req_t exp_issue[$];
  int       start_cycles[$];
  int       done_cycle[NREQ];

  logic     m_busy;
  int       m_cnt;
  div_req_t m_op;
  div_req_t mon_e;
  res_t     mon_r;
  vec_t     vecs[8];

  div_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQUESTERS(NREQ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_start     (req_start),
    .req_op        (req_op),
    .req_done      (req_done),
    .req_quotient  (req_quotient),
    .req_remainder (req_remainder),
    .req_busy      (req_busy),
    .div_start     (div_start),
    .div_op        (div_op),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DIV_CLZ_WIDTH-1:0] clz(input logic [DW-1:0] v);
    int n;
    n = 0;
    for (int b = DW - 1; b >= 0; b--) begin
      if (v[b]) break;
      n++;
    end
    return DIV_CLZ_WIDTH'(n);
  endfunction

  function automatic div_req_t make_op(input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                                       input logic dz);
    div_req_t o;
    o.dividend        = dvd;
    o.dividend_clz    = clz(dvd);
    o.divisor         = dvs;
    o.divisor_clz     = clz(dvs);
    o.divisor_is_zero = dz;
    return o;
  endfunction

  function automatic logic [DW-1:0] fair_dvd(input int i, input int k);
    return DW'(1000 + 37 * k + 500 * i);
  endfunction

  function automatic logic [DW-1:0] fair_dvs(input int i, input int k);
    return DW'(3 + i + 2 * k);
  endfunction

  // Behavioural divider; divide-by-zero returns all ones and the dividend.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy        <= 1'b0;
      m_cnt         <= 0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !m_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_op   <= div_op;
      end else if (m_busy) begin
        check("div_op_stable", div_op, m_op);
        if (m_cnt == DIV_LAT - 1) begin
          m_busy        <= 1'b0;
          div_done      <= 1'b1;
          div_quotient  <= m_op.divisor_is_zero ? '1 : m_op.dividend / m_op.divisor;
          div_remainder <= m_op.divisor_is_zero ? m_op.dividend : m_op.dividend % m_op.divisor;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (div_start) begin
        start_cycles.push_back(cycle);
        if (exp_issue.size() == 0) check("unexpected_div_start", 1'b1, 1'b0);
        else begin
          mon_e = exp_issue.pop_front();
          check("issue_op", div_op, mon_e);
        end
      end
      if (req_done != '0) begin
        check("done_onehot", $countones(req_done), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (req_done[i]) begin
            done_cycle[i] = cycle;
            if (exp_res[i].size() == 0) check("unexpected_req_done", 1'b1, 1'b0);
            else begin
              mon_r = exp_res[i].pop_front();
              check("quotient", req_quotient, mon_r.q);
              check("remainder", req_remainder, mon_r.r);
            end
          end
        end
      end
    end
  end

  task automatic start_req(input int id, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                           input logic dz, input logic [DW-1:0] q, input logic [DW-1:0] r,
                           input bit push_issue);
    div_req_t op;
    res_t     e;
    op            = make_op(dvd, dvs, dz);
    req_op[id]    = op;
    req_start[id] = 1'b1;
    e.q = q;
    e.r = r;
    exp_res[id].push_back(e);
    if (push_issue) exp_issue.push_back(op);
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    req_start = '0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((exp_res[0].size() != 0 || exp_res[1].size() != 0 || req_busy != '0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("quiet_within_budget", n < budget, 1'b1);
  endtask

  task automatic check_outputs_zero();
    check("rst_req_done", req_done, '0);
    check("rst_req_quotient", req_quotient, '0);
    check("rst_req_remainder", req_remainder, '0);
    check("rst_req_busy", req_busy, '0);
    check("rst_div_start", div_start, 1'b0);
    check("rst_div_op", div_op, '0);
  endtask

  initial begin
    int c0;
    int started[NREQ];

    vecs[0] = '{0, 32'd1000,        32'd10,          1'b0, 32'd100,         32'd0};
    vecs[1] = '{1, 32'd12345,       32'd1,           1'b0, 32'd12345,       32'd0};
    vecs[2] = '{0, 32'd0,           32'd9,           1'b0, 32'd0,           32'd0};
    vecs[3] = '{1, 32'd5,           32'd9,           1'b0, 32'd0,           32'd5};
    vecs[4] = '{0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0, 32'd1,           32'd0};
    vecs[5] = '{1, 32'hFFFF_FFFF,   32'd2,           1'b0, 32'h7FFF_FFFF,   32'd1};
    vecs[6] = '{0, 32'h8000_0000,   32'd3,           1'b0, 32'h2AAA_AAAA,   32'd2};
    vecs[7] = '{1, 32'd42,          32'd0,           1'b1, 32'hFFFF_FFFF,   32'd42};

    rst_n     = 1'b0;
    req_start = '0;
    req_op    = '0;
    #1;
    check_outputs_zero();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero();

    // Single request 100/7: issue latency, completion latency, busy release.
    start_cycles.delete();
    c0 = cycle;
    start_req(0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
    check("busy_before_capture", req_busy[0], 1'b0);
    pulse();
    wait_quiet(40);
    check("single_issue_cycle", start_cycles[0] - c0, ISSUE_LAT);
    check("single_done_cycle", done_cycle[0] - c0, ISSUE_LAT + DIV_LAT + 1);
    @(posedge clk);
    #1;
    check("single_busy_released", req_busy[0], 1'b0);

    // Vector table: one request at a time on alternating ports.
    for (int t = 0; t < 8; t++) begin
      start_req(vecs[t].id, vecs[t].dividend, vecs[t].divisor, vecs[t].dz,
                vecs[t].q, vecs[t].r, 1'b1);
      pulse();
      wait_quiet(40);
    end

    // Contention after reset pointer state: requester 0 first, second issue overlaps done.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_cycles.delete();
    c0 = cycle;
    start_req(0, 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b1);
    start_req(1, 32'd9,  32'd4, 1'b0, 32'd2,  32'd1, 1'b1);
    pulse();
    wait_quiet(60);
    check("cont_first_issue", start_cycles[0] - c0, ISSUE_LAT);
    check("cont_second_issue_overlaps_done", start_cycles[1], done_cycle[0]);
    check("cont_second_done", done_cycle[1] - done_cycle[0], DIV_LAT + 1);

    // Fairness: both restart on every done; grants must alternate 0,1,0,1,...
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_cycles.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NREQ; i++)
        exp_issue.push_back(make_op(fair_dvd(i, k), fair_dvs(i, k), 1'b0));
    for (int i = 0; i < NREQ; i++) begin
      start_req(i, fair_dvd(i, 0), fair_dvs(i, 0), 1'b0,
                fair_dvd(i, 0) / fair_dvs(i, 0), fair_dvd(i, 0) % fair_dvs(i, 0), 1'b0);
      started[i] = 1;
    end
    c0 = 0;
    while ((started[0] < 4 || started[1] < 4) && c0 < 300) begin
      @(posedge clk);
      #1;
      req_start = '0;
      c0++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_done[i] && started[i] < 4) begin
          start_req(i, fair_dvd(i, started[i]), fair_dvs(i, started[i]), 1'b0,
                    fair_dvd(i, started[i]) / fair_dvs(i, started[i]),
                    fair_dvd(i, started[i]) % fair_dvs(i, started[i]), 1'b0);
          started[i]++;
        end
      end
    end
    check("fair_restart_budget", c0 < 300, 1'b1);
    pulse();
    wait_quiet(60);
    check("fair_issue_drained", exp_issue.size(), 0);
    check("fair_issue_count", start_cycles.size(), 8);
    for (int k = 1; k < 8 && k < start_cycles.size(); k++)
      check("fair_issue_gap", start_cycles[k] - start_cycles[k-1], DIV_LAT + 1);

    // Illegal restart while busy: dropped, original result intact, no extra issue.
    c0 = cycle;
    start_req(1, 32'd77, 32'd7, 1'b0, 32'd11, 32'd0, 1'b1);
    pulse();
    @(posedge clk);
    #1;
    check("illegal_busy_seen", req_busy[1], 1'b1);
    req_op[1]    = make_op(32'd99, 32'd2, 1'b0);
    req_start[1] = 1'b1;
    pulse();
    wait_quiet(40);
    repeat (4) @(posedge clk);
    #1;
    check("illegal_no_pending", req_busy, '0);
    check("illegal_issue_drained", exp_issue.size(), 0);

    // Reset mid-BUSY: everything clears asynchronously, then a fresh op works.
    c0 = cycle;
    start_req(0, 32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 1'b1);
    pulse();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("midrst_still_busy", req_busy[0], 1'b1);
    rst_n = 1'b0;
    exp_issue.delete();
    for (int i = 0; i < NREQ; i++) exp_res[i].delete();
    #1;
    check_outputs_zero();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_req(0, 32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b1);
    pulse();
    wait_quiet(40);
    check("midrst_final_quotient", req_quotient, 32'd6);
    check("midrst_final_remainder", req_remainder, 32'd2);

`ifdef DIV_SHARE_ARBITER_BYPASS_EN
    // Idle bypass: div_start in the same cycle as req_start.
    start_cycles.delete();
    c0 = cycle;
    start_req(0, 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b1);
    #1;
    check("bypass_same_cycle_start", div_start, 1'b1);
    check("bypass_same_cycle_dividend", div_op.dividend, 32'd81);
    pulse();
    wait_quiet(40);
    check("bypass_done_cycle", done_cycle[0] - c0, DIV_LAT + 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_issue_drained", exp_issue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one unsigned divider (unsigned_division_interface, divider side) between NUM_REQUESTERS requesters, e.g. integer div unit and FP div/sqrt mantissa path.
- Captures single-cycle start pulses into per-requester one-entry holding buffers and issues them to the divider one at a time in round-robin order.
- Routes quotient, remainder and a done pulse back to the owning requester only.
- Sits between the execution units and the single divider instance in the core.

Parameters:
- DATA_WIDTH, 32, operand/result width; CLZ fields are $clog2(DATA_WIDTH) bits.
- NUM_REQUESTERS, 2, number of requester ports; legal range 2..4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- req_start  in  NUM_REQUESTERS  per-requester single-cycle start pulse.
- req_op  in  NUM_REQUESTERS x div_req_t  per-requester operands: dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero.
- req_done  out  NUM_REQUESTERS  single-cycle completion pulse to the owner.
- req_quotient  out  DATA_WIDTH  registered quotient, shared bus, qualified by req_done.
- req_remainder  out  DATA_WIDTH  registered remainder, shared bus, qualified by req_done.
- req_busy  out  NUM_REQUESTERS  requester has an accepted, uncompleted request.
- div_start  out  1  start pulse to the divider.
- div_op  out  div_req_t  operands to the divider, held stable from div_start until div_done.
- div_done  in  1  divider completion pulse.
- div_quotient  in  DATA_WIDTH  divider quotient.
- div_remainder  in  DATA_WIDTH  divider remainder.

Behaviour:
- Reset values: all outputs 0; all buffers empty; FSM in IDLE; rr pointer = 0; owner = 0.
- Capture: req_start[i] writes req_op[i] into buf[i] and sets pend[i] on the next edge.
- req_busy[i] = pend[i] OR (state == BUSY AND owner == i).
- Protocol: req_start[i] while req_busy[i] is illegal. A simulation assertion fires, and the request is dropped with no buffer overwrite.
- FSM IDLE: if any pend bit is set, select a winner by round-robin starting at the rr pointer. In the same cycle:
  - assert div_start;
  - drive div_op = buf[winner];
  - clear pend[winner];
  - owner <= winner;
  - rr pointer <= winner+1 mod NUM_REQUESTERS;
  - go to BUSY.
- FSM BUSY: div_op stays at the latched owner operands. On div_done:
  - register quotient and remainder;
  - pulse req_done[owner] on the next cycle;
  - go to IDLE.
- Latency with no contention:
  - req_start at cycle 0;
  - div_start at cycle 1;
  - div_done at cycle D;
  - req_done and results at cycle D+1.
- Back-to-back issue: the earliest next div_start is cycle D+1 (IDLE with pend set), overlapping the previous req_done.
- Simultaneous starts: all are captured. Grant order follows the rr pointer; after reset requester 0 wins.
- A requester may pulse a new req_start in the same cycle its req_done is asserted; it is accepted.
- divisor_is_zero: passed through unchanged. The arbiter does not special-case it; the divider handles it.
- req_quotient and req_remainder hold their last values until the next completion.
- div_done while IDLE is an assertion failure and is ignored.
- Reset asserted mid-operation: all state clears asynchronously and no req_done is produced. The divider is reset on the same rst_n.

Optional Feature:
- DIV_SHARE_ARBITER_BYPASS_EN defined: in IDLE with no pend bits set, an incoming req_start[i] is issued combinationally.
  - div_start is asserted and div_op = req_op[i] in cycle 0; the buffer is not written.
  - Lowest index wins among simultaneous starts, with the others buffered normally.
  - Latency becomes req_start at 0 -> req_done at D+1 with div_start at 0.
- Undefined: the registered capture path above; div_start is always at least one cycle after req_start.

Decomposition:
- Shared package (cva5_types or a new div_share_types): div_req_t packed struct; div_arb_state_t enum {IDLE, BUSY}; owner index width $clog2(NUM_REQUESTERS).
- Sub-module div_rr_select: combinational round-robin select from the pend vector and pointer.
  - Outputs: grant one-hot, grant index, any_valid.
- Top level holds the buffers, FSM, owner, result registers and assertions.

Test Plan:
- Single request: req0 100/7 at cycle 0, divider model D=5 -> div_start at cycle 1, req_done[0] at cycle 6, quotient 14, remainder 2, req_busy[0] low after cycle 6.
- Contention: req0 50/5 and req1 9/4 in the same cycle after reset -> req0 issued first (q 10 r 0), req1 issued at req0's D+1 (q 2 r 1), req_done never on both ports at once.
- Fairness: both requesters restart on every done for 8 operations -> grants strictly alternate 0,1,0,1; no requester waits more than one divider operation.
- Illegal restart: req1 start while req_busy[1] -> assertion fires, buffer unchanged, original result returned correctly.
- Reset mid-BUSY: rst_n low at cycle 3 of a 7/2 op -> all outputs 0 immediately; after release, a new 20/3 op returns q 6 r 2.
- With DIV_SHARE_ARBITER_BYPASS_EN: idle req0 start 81/9 -> div_start in the same cycle, req_done at D+1 with q 9 r 0.
